// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and the round-robin pick function for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int MAX_SRC = 32;
    localparam int MAX_W   = $clog2(MAX_SRC);

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    typedef struct packed {
        logic       found;
        logic [7:0] id;
    } rr_t;

    // Rotate req so bit 0 is source last_id+1, take the lowest set bit, rotate the index back.
    function automatic rr_t rr_next(input int n, input logic [MAX_SRC-1:0] req, input int last_id);
        rr_t                r;
        int                 base;
        int                 idx;
        logic [MAX_SRC-1:0] rot;
        base = (last_id + 1 >= n) ? 0 : last_id + 1;
        rot  = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            idx = (base + i >= n) ? base + i - n : base + i;
            if (i < n)
                rot[i] = req[idx[MAX_W-1:0]];
        end
        r = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            idx = (base + i >= n) ? base + i - n : base + i;
            if (rot[i]) begin
                r.found = 1'b1;
                r.id    = idx[7:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin choice of the next requester after last_id.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last_id,
    output logic               found,
    output logic [SRC_W-1:0]   id
);

    rr_t pick;

    always_comb begin
        pick  = rr_next(NUM_SRC, MAX_SRC'(req), int'(last_id));
        found = pick.found;
        id    = pick.id[SRC_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin arbiter feeding one FIFO write port with {src_id, data} beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int DATA_W  = 8,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_SRC-1:0]             i_req,
    input  logic [NUM_SRC-1:0][DATA_W-1:0] i_data,
    input  logic [NUM_SRC-1:0]             i_last,
    output logic [NUM_SRC-1:0]             o_ack,
    output logic                           o_fifo_wr,
    output logic [SRC_W+DATA_W-1:0]        o_fifo_wdata,
    input  logic                           i_fifo_full,
    output logic                           o_grant_valid,
    output logic [SRC_W-1:0]               o_grant_id
);

    arb_state_e       state, nxt;
    logic [SRC_W-1:0] grant_id, last_id, pick_id;
    logic             pick_found, xfer, done;

    rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req     (i_req),
        .last_id (last_id),
        .found   (pick_found),
        .id      (pick_id)
    );

    // Full gates the handshake in the same cycle so no beat is ever dropped by the FIFO.
    assign xfer = (state == ARB_GRANT) && i_req[grant_id] && !i_fifo_full;
    assign done = xfer && i_last[grant_id];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ARB_IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_id <= '0;
            last_id  <= SRC_W'(NUM_SRC - 1);
        end else begin
            if (state == ARB_IDLE && pick_found)
                grant_id <= pick_id;
            if (done)
                last_id <= grant_id;
        end
    end

    always_comb begin
        nxt = (state == ARB_IDLE) ? (pick_found ? ARB_GRANT : ARB_IDLE)
                                  : (done ? ARB_IDLE : ARB_GRANT);
    end

    always_comb begin
        o_fifo_wr     = xfer;
        o_ack         = xfer ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << grant_id) : '0;
        o_fifo_wdata  = xfer ? {grant_id, i_data[grant_id]} : '0;
        o_grant_valid = (state == ARB_GRANT);
        o_grant_id    = (state == ARB_GRANT) ? grant_id : '0;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios checked every cycle against a packet-level round-robin model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic              clk = 0;
    logic              rst = 1;
    logic              full = 0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      last = '0;
    logic [N-1:0][DW-1:0] data = '0;
    logic [N-1:0]      o_ack;
    logic              o_fifo_wr;
    logic [SW+DW-1:0]  o_fifo_wdata;
    logic              o_grant_valid;
    logic [SW-1:0]     o_grant_id;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int w_src[$];
    int w_dat[$];
    int w_cyc[$];

    bit m_gnt  = 0;
    int m_own  = 0;
    int m_last = N - 1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_SRC(N), .DATA_W(DW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_data        (data),
        .i_last        (last),
        .o_ack         (o_ack),
        .o_fifo_wr     (o_fifo_wr),
        .o_fifo_wdata  (o_fifo_wdata),
        .i_fifo_full   (full),
        .o_grant_valid (o_grant_valid),
        .o_grant_id    (o_grant_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        w_src.delete();
        w_dat.delete();
        w_cyc.delete();
    endtask

    always @(posedge clk) cyc++;

    // Model holds the owner for a whole packet; new owner is the first requester after the previous owner.
    always @(negedge clk) begin
        bit wr;
        if (cyc > 0) begin
            wr = m_gnt && req[m_own] && !full;
            chk("wr", o_fifo_wr, wr);
            chk("ack", o_ack, wr ? (4'b0001 << m_own) : 4'b0000);
            chk("wdata", o_fifo_wdata, wr ? {m_own[1:0], data[m_own]} : 10'b0);
            chk("gvalid", o_grant_valid, m_gnt);
            chk("gid", o_grant_id, m_gnt ? m_own : 0);
            if (o_fifo_wr) begin
                w_src.push_back(int'(o_fifo_wdata[SW+DW-1:DW]));
                w_dat.push_back(int'(o_fifo_wdata[DW-1:0]));
                w_cyc.push_back(cyc);
            end
            if (rst) begin
                m_gnt  = 0;
                m_own  = 0;
                m_last = N - 1;
            end else if (!m_gnt) begin
                for (int k = 1; k <= N; k++)
                    if (!m_gnt && req[(m_last + k) % N]) begin
                        m_own = (m_last + k) % N;
                        m_gnt = 1;
                    end
            end else if (wr && last[m_own]) begin
                m_last = m_own;
                m_gnt  = 0;
            end
        end
    end

    initial begin
        logic [7:0] exp_sp[3];
        logic [7:0] exp_bp[4];
        int         n0;
        exp_sp = '{8'hA1, 8'hB2, 8'hC3};
        exp_bp = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};

        chk("rr_wrap", rr_next(4, 32'b1010, 3).id, 1);
        chk("rr_skip", rr_next(4, 32'b0011, 0).id, 1);
        chk("rr_after_last", rr_next(4, 32'b0001, 2).id, 0);
        chk("rr_none", rr_next(4, 32'b0000, 1).found, 0);

        // Reset with every source requesting
        req  = '1;
        last = '1;
        data = {8'h33, 8'h22, 8'h11, 8'h00};
        repeat (3) tick();
        chk("rst_gvalid", o_grant_valid, 0);
        chk("rst_wr", o_fifo_wr, 0);
        chk("rst_ack", o_ack, 0);
        rst = 0;
        tick();
        chk("rel_gvalid", o_grant_valid, 1);
        chk("rel_gid", o_grant_id, 0);
        tick();
        req  = '0;
        last = '0;
        repeat (2) tick();

        // Single 3-beat packet from source 2
        clear_log();
        req     = 4'b0100;
        data[2] = 8'hA1;
        tick();
        tick();
        data[2] = 8'hB2;
        tick();
        data[2] = 8'hC3;
        last[2] = 1;
        tick();
        req  = '0;
        last = '0;
        chk("sp_idle_after", o_grant_valid, 0);
        tick();
        chk("sp_count", w_src.size(), 3);
        for (int i = 0; i < w_src.size() && i < 3; i++) begin
            chk("sp_src", w_src[i], 2);
            chk("sp_data", w_dat[i], exp_sp[i]);
            chk("sp_consec", w_cyc[i] - w_cyc[0], i);
        end

        // Fairness between two streams of 1-beat packets
        clear_log();
        req     = 4'b0011;
        last    = 4'b0011;
        data[0] = 8'h50;
        data[1] = 8'h51;
        repeat (20) tick();
        req  = '0;
        last = '0;
        tick();
        chk("fair_count", w_src.size(), 10);
        n0 = 0;
        for (int i = 0; i < w_src.size(); i++) begin
            if (w_src[i] == 0)
                n0++;
            chk("fair_order", w_src[i], i % 2);
            if (i > 0)
                chk("fair_gap", w_cyc[i] - w_cyc[i-1], 2);
        end
        chk("fair_src0", n0, 5);

        // Backpressure on beat 2 of a 4-beat packet from source 3
        clear_log();
        req     = 4'b1000;
        data[3] = 8'hD0;
        tick();
        tick();
        data[3] = 8'hD1;
        full    = 1;
        repeat (5) begin
            tick();
            chk("bp_gid", o_grant_id, 3);
        end
        full = 0;
        tick();
        data[3] = 8'hD2;
        tick();
        data[3] = 8'hD3;
        last[3] = 1;
        tick();
        req  = '0;
        last = '0;
        tick();
        chk("bp_count", w_src.size(), 4);
        for (int i = 0; i < w_src.size() && i < 4; i++) begin
            chk("bp_src", w_src[i], 3);
            chk("bp_data", w_dat[i], exp_bp[i]);
        end
        if (w_cyc.size() == 4) begin
            chk("bp_stall", w_cyc[1] - w_cyc[0], 6);
            chk("bp_resume", w_cyc[3] - w_cyc[1], 2);
        end

        // Packet lock: source 3 pauses while source 1 requests
        clear_log();
        req     = 4'b1000;
        data[3] = 8'hE0;
        tick();
        tick();
        req     = 4'b0010;
        data[1] = 8'hF0;
        last[1] = 1;
        repeat (4) begin
            tick();
            chk("lk_gvalid", o_grant_valid, 1);
            chk("lk_gid", o_grant_id, 3);
        end
        req     = 4'b1010;
        data[3] = 8'hE1;
        last[3] = 1;
        tick();
        req     = 4'b0010;
        last[3] = 0;
        tick();
        chk("lk_next_gid", o_grant_id, 1);
        tick();
        req  = '0;
        last = '0;
        tick();
        chk("lk_count", w_src.size(), 3);
        if (w_src.size() == 3) begin
            chk("lk_src0", w_src[0], 3);
            chk("lk_src1", w_src[1], 3);
            chk("lk_src2", w_src[2], 1);
            chk("lk_dat1", w_dat[1], 8'hE1);
            chk("lk_dat2", w_dat[2], 8'hF0);
        end

        // Reset in the middle of a source-2 packet
        req     = 4'b0100;
        data[2] = 8'h60;
        tick();
        tick();
        req     = 4'b0101;
        data[0] = 8'h70;
        last[0] = 1;
        rst     = 1;
        tick();
        chk("mr_gvalid", o_grant_valid, 0);
        rst = 0;
        tick();
        chk("mr_gvalid2", o_grant_valid, 1);
        chk("mr_gid", o_grant_id, 0);
        tick();
        req  = '0;
        last = '0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
